// File: rtl/otter_mem2_arbiter.sv
// otter_mem2_arbiter: shares OTTER memory data port 2 between the CPU MEM
// stage (priority owner) and a secondary DMA master. A DMA request that has
// been denied MAX_WAIT times is force-granted once, stalling the CPU for that
// cycle. A COOLDOWN window follows each forced grant, during which no further
// forced grant can occur.
module otter_mem2_arbiter #(
  parameter int unsigned MAX_WAIT = 8,
  parameter int unsigned COOLDOWN = 4
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        CPU_MEM_READ,
  input  logic        CPU_MEM_WRITE,
  input  logic [31:0] CPU_ADDR,
  input  logic [31:0] CPU_DIN,
  input  logic [1:0]  CPU_SIZE,
  input  logic        CPU_SIGN,
  output logic        CPU_STALL,
  output logic [31:0] CPU_DOUT,
  input  logic        DMA_VALID,
  input  logic        DMA_WE,
  input  logic [31:0] DMA_ADDR,
  input  logic [31:0] DMA_DIN,
  input  logic [1:0]  DMA_SIZE,
  output logic        DMA_READY,
  output logic [31:0] DMA_RDATA,
  output logic        DMA_RVALID,
  output logic [31:0] MEM_ADDR2,
  output logic [31:0] MEM_DIN2,
  output logic [1:0]  MEM_SIZE,
  output logic        MEM_SIGN,
  output logic        MEM_WRITE2,
  output logic        MEM_READ2,
  input  logic [31:0] MEM_DOUT2
);

  typedef enum logic {
    NORMAL = 1'b0,
    COOL   = 1'b1
  } state_t;

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);
  localparam logic [7:0] COOLDOWN_C = 8'(COOLDOWN);

  state_t     state, state_next;
  logic [7:0] wait_cnt, wait_next;
  logic [7:0] cool_cnt, cool_next;
  logic       dma_rd_q, dma_rd_next;

  logic cpu_req;
  logic force_grant;
  logic dma_grant;

  // Grant decision: CPU wins unless it is idle or the DMA has waited long enough.
  always_comb begin
    cpu_req     = CPU_MEM_READ | CPU_MEM_WRITE;
    force_grant = (state == NORMAL) && DMA_VALID && (wait_cnt == MAX_WAIT_C);
    dma_grant   = force_grant || (DMA_VALID && !cpu_req);
  end

  // Port 2 multiplexing and handshake outputs for the current owner.
  always_comb begin
    MEM_ADDR2  = CPU_ADDR;
    MEM_DIN2   = CPU_DIN;
    MEM_SIZE   = CPU_SIZE;
    MEM_SIGN   = CPU_SIGN;
    MEM_WRITE2 = CPU_MEM_WRITE;
    MEM_READ2  = CPU_MEM_READ;
    if (dma_grant) begin
      MEM_ADDR2  = DMA_ADDR;
      MEM_DIN2   = DMA_DIN;
      MEM_SIZE   = DMA_SIZE;
      MEM_SIGN   = 1'b0;
      MEM_WRITE2 = DMA_WE;
      MEM_READ2  = !DMA_WE;
    end
    DMA_READY  = dma_grant;
    CPU_STALL  = dma_grant && cpu_req;
    DMA_RVALID = dma_rd_q;
  end

  assign DMA_RDATA = MEM_DOUT2;
  assign CPU_DOUT  = MEM_DOUT2;

  // Next-state logic for the cooldown FSM, starvation counter and read return.
  always_comb begin
    state_next  = state;
    cool_next   = cool_cnt;
    wait_next   = wait_cnt;
    dma_rd_next = dma_grant && !DMA_WE;

    case (state)
      NORMAL: begin
        if (force_grant && (COOLDOWN_C != 8'd0)) begin
          state_next = COOL;
          cool_next  = COOLDOWN_C;
        end
      end
      COOL: begin
        cool_next = cool_cnt - 8'd1;
        // <= 1 rather than == 1 so a corrupted zero count cannot lock COOL.
        if (cool_cnt <= 8'd1) begin
          state_next = NORMAL;
        end
      end
      default: begin
        state_next = NORMAL;
        cool_next  = '0;
      end
    endcase

    if (dma_grant || (state == COOL)) begin
      wait_next = '0;
    end else if (DMA_VALID && (wait_cnt != MAX_WAIT_C)) begin
      wait_next = wait_cnt + 8'd1;
    end
  end

  // State register; synchronous active-low reset overrides every update.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state    <= NORMAL;
      wait_cnt <= '0;
      cool_cnt <= '0;
      dma_rd_q <= 1'b0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_next;
      cool_cnt <= cool_next;
      dma_rd_q <= dma_rd_next;
    end
  end

endmodule

// File: tb/tb_otter_mem2_arbiter.sv
// Bench for otter_mem2_arbiter: directed vector table, hand-written
// multi-cycle sequences, and randomized traffic against a reference model.
module tb_otter_mem2_arbiter;

  localparam int MW = 8;
  localparam int CD = 4;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        CPU_MEM_READ, CPU_MEM_WRITE, CPU_SIGN;
  logic [31:0] CPU_ADDR, CPU_DIN;
  logic [1:0]  CPU_SIZE;
  logic        DMA_VALID, DMA_WE;
  logic [31:0] DMA_ADDR, DMA_DIN;
  logic [1:0]  DMA_SIZE;
  logic [31:0] MEM_DOUT2;

  logic        CPU_STALL, DMA_READY, DMA_RVALID, MEM_SIGN, MEM_WRITE2, MEM_READ2;
  logic [31:0] CPU_DOUT, DMA_RDATA, MEM_ADDR2, MEM_DIN2;
  logic [1:0]  MEM_SIZE;

  logic        b_stall, b_ready, b_rvalid, b_sign, b_write2, b_read2;
  logic [31:0] b_dout, b_rdata, b_addr2, b_din2;
  logic [1:0]  b_size;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  otter_mem2_arbiter #(.MAX_WAIT(MW), .COOLDOWN(CD)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .CPU_MEM_READ(CPU_MEM_READ), .CPU_MEM_WRITE(CPU_MEM_WRITE),
    .CPU_ADDR(CPU_ADDR), .CPU_DIN(CPU_DIN), .CPU_SIZE(CPU_SIZE), .CPU_SIGN(CPU_SIGN),
    .CPU_STALL(CPU_STALL), .CPU_DOUT(CPU_DOUT),
    .DMA_VALID(DMA_VALID), .DMA_WE(DMA_WE), .DMA_ADDR(DMA_ADDR), .DMA_DIN(DMA_DIN),
    .DMA_SIZE(DMA_SIZE), .DMA_READY(DMA_READY), .DMA_RDATA(DMA_RDATA), .DMA_RVALID(DMA_RVALID),
    .MEM_ADDR2(MEM_ADDR2), .MEM_DIN2(MEM_DIN2), .MEM_SIZE(MEM_SIZE), .MEM_SIGN(MEM_SIGN),
    .MEM_WRITE2(MEM_WRITE2), .MEM_READ2(MEM_READ2), .MEM_DOUT2(MEM_DOUT2)
  );

  otter_mem2_arbiter #(.MAX_WAIT(MW), .COOLDOWN(0)) dut_nocool (
    .CLK(CLK), .RESET_N(RESET_N),
    .CPU_MEM_READ(CPU_MEM_READ), .CPU_MEM_WRITE(CPU_MEM_WRITE),
    .CPU_ADDR(CPU_ADDR), .CPU_DIN(CPU_DIN), .CPU_SIZE(CPU_SIZE), .CPU_SIGN(CPU_SIGN),
    .CPU_STALL(b_stall), .CPU_DOUT(b_dout),
    .DMA_VALID(DMA_VALID), .DMA_WE(DMA_WE), .DMA_ADDR(DMA_ADDR), .DMA_DIN(DMA_DIN),
    .DMA_SIZE(DMA_SIZE), .DMA_READY(b_ready), .DMA_RDATA(b_rdata), .DMA_RVALID(b_rvalid),
    .MEM_ADDR2(b_addr2), .MEM_DIN2(b_din2), .MEM_SIZE(b_size), .MEM_SIGN(b_sign),
    .MEM_WRITE2(b_write2), .MEM_READ2(b_read2), .MEM_DOUT2(MEM_DOUT2)
  );

  typedef struct {
    logic        crd, cwr;
    logic [31:0] caddr, cdin;
    logic [1:0]  csize;
    logic        csign;
    logic        dv, dwe;
    logic [31:0] daddr, ddin;
    logic [1:0]  dsize;
    logic        e_ready, e_rd, e_wr;
    logic [31:0] e_addr, e_din;
    logic [1:0]  e_size;
    logic        e_sign;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    CPU_MEM_READ = 0; CPU_MEM_WRITE = 0; CPU_ADDR = 32'h0000_0100; CPU_DIN = 32'h1;
    CPU_SIZE = 2'd2; CPU_SIGN = 0;
    DMA_VALID = 0; DMA_WE = 0; DMA_ADDR = 32'h6000; DMA_DIN = 0; DMA_SIZE = 2'd2;
    MEM_DOUT2 = 0;
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET_N = 0;
    idle_inputs();
    next_cycle();
    RESET_N = 1;
  endtask

  // Continuous CPU reads and DMA writes for n cycles; record stall cycles.
  task automatic stream(input int n, output int sa[$], output int sb[$]);
    sa = {};
    sb = {};
    CPU_MEM_READ = 1;
    DMA_VALID = 1; DMA_WE = 1; DMA_ADDR = 32'h6004; DMA_DIN = 32'h1234_5678;
    for (int c = 1; c <= n; c++) begin
      #2;
      chk($sformatf("stream_ready_eq_stall_c%0d", c), DMA_READY, CPU_STALL);
      if (CPU_STALL) sa.push_back(c);
      if (b_stall) sb.push_back(c);
      next_cycle();
    end
    idle_inputs();
  endtask

  int sa[$], sb[$];
  int exp_a[$] = '{9, 22, 35};
  int exp_b[$] = '{9, 18, 27, 36};

  // Reference model state for the random phase.
  int  denied, cool_until;
  bit  rd_pend, dma_hold, creq, in_cool, frc, gnt;
  int unsigned r;

  initial begin
    RESET_N = 0;
    idle_inputs();
    next_cycle();
    next_cycle();

    // Reset held with competing requests; no read-return may appear.
    CPU_MEM_READ = 1; DMA_VALID = 1; DMA_WE = 0; DMA_ADDR = 32'h6008;
    for (int c = 0; c < 2; c++) begin
      #2;
      chk("reset_rvalid", DMA_RVALID, 0);
      next_cycle();
    end
    RESET_N = 1;
    for (int c = 1; c <= 10; c++) begin
      #2;
      if (c == 1) begin
        chk("post_reset_rvalid", DMA_RVALID, 0);
        chk("post_reset_cpu_read", MEM_READ2, 1);
        chk("post_reset_addr", MEM_ADDR2, 32'h0000_0100);
      end
      if (c <= 9) chk($sformatf("post_reset_ready_c%0d", c), DMA_READY, (c == 9));
      if (c == 10) chk("post_reset_forced_read_rvalid", DMA_RVALID, 1);
      if (c == 9) DMA_VALID = 1;
      next_cycle();
      if (c == 9) DMA_VALID = 0;
    end

    // DMA read granted during reset must not return data.
    RESET_N = 0;
    idle_inputs();
    DMA_VALID = 1;
    #2;
    chk("reset_cycle_dma_ready", DMA_READY, 1);
    next_cycle();
    RESET_N = 1;
    DMA_VALID = 0;
    #2;
    chk("reset_cycle_read_no_rvalid", DMA_RVALID, 0);
    next_cycle();

    // Directed combinational vectors.
    do_reset();
    vt[0] = '{0,0,32'hA0,32'hB0,2'd1,1, 0,0,32'h6000,32'hD0,2'd0, 0,0,0,32'hA0,32'hB0,2'd1,1};
    vt[1] = '{1,0,32'hA1,32'hB1,2'd1,1, 0,0,32'h6000,32'hD0,2'd0, 0,1,0,32'hA1,32'hB1,2'd1,1};
    vt[2] = '{0,1,32'hA2,32'hB2,2'd0,0, 0,0,32'h6000,32'hD0,2'd0, 0,0,1,32'hA2,32'hB2,2'd0,0};
    vt[3] = '{0,0,32'hA3,32'hB3,2'd1,1, 1,0,32'h6010,32'hD3,2'd2, 1,1,0,32'h6010,32'hD3,2'd2,0};
    vt[4] = '{0,0,32'hA4,32'hB4,2'd1,1, 1,1,32'h6014,32'hD4,2'd0, 1,0,1,32'h6014,32'hD4,2'd0,0};
    vt[5] = '{1,0,32'hA5,32'hB5,2'd2,1, 1,1,32'h6018,32'hD5,2'd1, 0,1,0,32'hA5,32'hB5,2'd2,1};
    vt[6] = '{0,1,32'hA6,32'hB6,2'd0,0, 1,1,32'h6018,32'hD5,2'd1, 0,0,1,32'hA6,32'hB6,2'd0,0};
    vt[7] = '{0,1,32'h1100_0000,32'hFF,2'd2,0, 0,0,32'h6000,32'h0,2'd0, 0,0,1,32'h1100_0000,32'hFF,2'd2,0};
    for (int i = 0; i < 8; i++) begin
      CPU_MEM_READ = vt[i].crd; CPU_MEM_WRITE = vt[i].cwr; CPU_ADDR = vt[i].caddr;
      CPU_DIN = vt[i].cdin; CPU_SIZE = vt[i].csize; CPU_SIGN = vt[i].csign;
      DMA_VALID = vt[i].dv; DMA_WE = vt[i].dwe; DMA_ADDR = vt[i].daddr;
      DMA_DIN = vt[i].ddin; DMA_SIZE = vt[i].dsize;
      #2;
      chk($sformatf("vec%0d_ready", i), DMA_READY, vt[i].e_ready);
      chk($sformatf("vec%0d_stall", i), CPU_STALL, 0);
      chk($sformatf("vec%0d_read2", i), MEM_READ2, vt[i].e_rd);
      chk($sformatf("vec%0d_write2", i), MEM_WRITE2, vt[i].e_wr);
      chk($sformatf("vec%0d_addr2", i), MEM_ADDR2, vt[i].e_addr);
      chk($sformatf("vec%0d_din2", i), MEM_DIN2, vt[i].e_din);
      chk($sformatf("vec%0d_size", i), MEM_SIZE, vt[i].e_size);
      chk($sformatf("vec%0d_sign", i), MEM_SIGN, vt[i].e_sign);
      next_cycle();
    end

    // Idle-port DMA read with one-cycle data return.
    do_reset();
    CPU_SIGN = 1; DMA_VALID = 1; DMA_WE = 0; DMA_ADDR = 32'h6000;
    #2;
    chk("idle_read_ready", DMA_READY, 1);
    chk("idle_read_read2", MEM_READ2, 1);
    chk("idle_read_sign", MEM_SIGN, 0);
    chk("idle_read_addr", MEM_ADDR2, 32'h6000);
    chk("idle_read_stall", CPU_STALL, 0);
    next_cycle();
    DMA_VALID = 0; MEM_DOUT2 = 32'hCAFE_F00D;
    #2;
    chk("idle_read_rvalid", DMA_RVALID, 1);
    chk("idle_read_rdata", DMA_RDATA, 32'hCAFE_F00D);
    chk("idle_read_stall2", CPU_STALL, 0);
    next_cycle();
    #2;
    chk("idle_read_rvalid_drop", DMA_RVALID, 0);
    next_cycle();

    // Starvation: forced DMA write on its 9th cycle.
    do_reset();
    CPU_MEM_READ = 1; DMA_VALID = 1; DMA_WE = 1; DMA_ADDR = 32'h6004; DMA_DIN = 32'h1234_5678;
    for (int c = 1; c <= 9; c++) begin
      #2;
      chk($sformatf("starve_ready_c%0d", c), DMA_READY, (c == 9));
      chk($sformatf("starve_stall_c%0d", c), CPU_STALL, (c == 9));
      if (c == 9) begin
        chk("starve_write2", MEM_WRITE2, 1);
        chk("starve_read2", MEM_READ2, 0);
        chk("starve_addr", MEM_ADDR2, 32'h6004);
        chk("starve_din", MEM_DIN2, 32'h1234_5678);
      end
      next_cycle();
    end

    // Cooldown spacing, with and without a cooldown window.
    do_reset();
    stream(40, sa, sb);
    chk("cool_stall_count", sa.size(), 3);
    chk("nocool_stall_count", sb.size(), 4);
    for (int i = 0; i < 3; i++)
      chk($sformatf("cool_stall_at_%0d", i), (i < sa.size()) ? sa[i] : -1, exp_a[i]);
    for (int i = 0; i < 4; i++)
      chk($sformatf("nocool_stall_at_%0d", i), (i < sb.size()) ? sb[i] : -1, exp_b[i]);

    // CPU idles for one cycle inside the COOL window.
    do_reset();
    CPU_MEM_READ = 1; DMA_VALID = 1; DMA_WE = 1; DMA_ADDR = 32'h600C;
    for (int c = 1; c <= 22; c++) begin
      CPU_MEM_READ = (c != 11);
      #2;
      chk($sformatf("coolidle_ready_c%0d", c), DMA_READY, (c == 9 || c == 11 || c == 22));
      chk($sformatf("coolidle_stall_c%0d", c), CPU_STALL, (c == 9 || c == 22));
      next_cycle();
    end

    // Randomized traffic against the reference model.
    do_reset();
    denied = 0; cool_until = 0; rd_pend = 0; dma_hold = 0;
    for (int c = 0; c < 600; c++) begin
      RESET_N = ($urandom_range(0, 79) != 0);
      r = $urandom_range(0, 9);
      CPU_MEM_READ  = (r < 6);
      CPU_MEM_WRITE = (r >= 6 && r < 9);
      CPU_ADDR = $urandom; CPU_DIN = $urandom;
      CPU_SIZE = 2'($urandom_range(0, 2)); CPU_SIGN = 1'($urandom_range(0, 1));
      if (!dma_hold) begin
        DMA_VALID = ($urandom_range(0, 3) != 0);
        DMA_WE = 1'($urandom_range(0, 1));
        DMA_ADDR = $urandom; DMA_DIN = $urandom; DMA_SIZE = 2'($urandom_range(0, 2));
      end
      MEM_DOUT2 = $urandom;

      creq    = CPU_MEM_READ | CPU_MEM_WRITE;
      in_cool = (c < cool_until);
      frc     = !in_cool && DMA_VALID && (denied == MW);
      gnt     = frc || (DMA_VALID && !creq);
      #2;
      chk("rnd_ready", DMA_READY, gnt);
      chk("rnd_stall", CPU_STALL, gnt && creq);
      chk("rnd_read2", MEM_READ2, gnt ? !DMA_WE : CPU_MEM_READ);
      chk("rnd_write2", MEM_WRITE2, gnt ? DMA_WE : CPU_MEM_WRITE);
      chk("rnd_addr2", MEM_ADDR2, gnt ? DMA_ADDR : CPU_ADDR);
      chk("rnd_din2", MEM_DIN2, gnt ? DMA_DIN : CPU_DIN);
      chk("rnd_size", MEM_SIZE, gnt ? DMA_SIZE : CPU_SIZE);
      chk("rnd_sign", MEM_SIGN, gnt ? 1'b0 : CPU_SIGN);
      chk("rnd_rvalid", DMA_RVALID, rd_pend);
      chk("rnd_rdata", DMA_RDATA, MEM_DOUT2);
      chk("rnd_cpu_dout", CPU_DOUT, MEM_DOUT2);

      dma_hold = DMA_VALID && !gnt;
      if (!RESET_N) begin
        denied = 0; cool_until = 0; rd_pend = 0;
      end else begin
        rd_pend = gnt && !DMA_WE;
        if (frc && CD > 0) cool_until = c + 1 + CD;
        if (gnt || in_cool) denied = 0;
        else if (DMA_VALID && denied < MW) denied++;
      end
      next_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
